// File: rtl/cpu_controller.sv
// Moore fetch/decode/execute controller: sequences PC, latches IR and drives RF/DMEM/ALU controls.
// Optional single-step mode (Step input, STEP_WAIT state) enabled by defining CPU_CTRL_SINGLE_STEP_EN.
module cpu_controller #(
    parameter int IW  = 16,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic           Clock,
    input  logic           Clr_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic           Step,
`endif
    input  logic [IW-1:0]  Instr,
    output logic           PC_clr,
    output logic           PC_up,
    output logic [DAW-1:0] D_addr,
    output logic           D_wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_addr,
    output logic [RAW-1:0] RF_Rb_addr,
    output logic [2:0]     ALU_s0,
    output logic           Halted
);

    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_LOAD_A    = 4'd3;
    localparam logic [3:0] S_LOAD_B    = 4'd4;
    localparam logic [3:0] S_STORE     = 4'd5;
    localparam logic [3:0] S_ADD       = 4'd6;
    localparam logic [3:0] S_SUB       = 4'd7;
    localparam logic [3:0] S_HALT      = 4'd8;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    localparam logic [3:0] S_STEP_WAIT = 4'd9;
    localparam logic [3:0] S_RESUME    = S_STEP_WAIT;
`else
    localparam logic [3:0] S_RESUME    = S_FETCH;
`endif

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    logic [3:0]    r_state;
    logic [3:0]    w_next_state;
    logic [IW-1:0] r_ir;
    logic [3:0]    w_opcode;

    assign w_opcode = r_ir[IW-1:IW-4];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state <= S_INIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= Instr;
            end
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = S_INIT;
        case (r_state)
            S_INIT:   w_next_state = S_RESUME;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_STORE: w_next_state = S_STORE;
                    OP_LOAD:  w_next_state = S_LOAD_A;
                    OP_ADD:   w_next_state = S_ADD;
                    OP_SUB:   w_next_state = S_SUB;
                    OP_HALT:  w_next_state = S_HALT;
                    OP_NOOP:  w_next_state = S_RESUME;
                    default:  w_next_state = S_RESUME;
                endcase
            end
            S_LOAD_A: w_next_state = S_LOAD_B;
            S_LOAD_B: w_next_state = S_RESUME;
            S_STORE:  w_next_state = S_RESUME;
            S_ADD:    w_next_state = S_RESUME;
            S_SUB:    w_next_state = S_RESUME;
            S_HALT:   w_next_state = S_HALT;
`ifdef CPU_CTRL_SINGLE_STEP_EN
            S_STEP_WAIT: w_next_state = Step ? S_FETCH : S_STEP_WAIT;
`endif
            default:  w_next_state = S_INIT;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = 3'b000;
        Halted     = 1'b0;
        case (r_state)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: PC_up  = 1'b1;
            S_LOAD_A, S_LOAD_B: begin
                // Both cycles hold the address; the write lands after the synchronous read returns.
                D_addr    = r_ir[DAW+RAW-1:RAW];
                RF_s      = 1'b1;
                RF_W_addr = r_ir[RAW-1:0];
                RF_W_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = r_ir[DAW-1:0];
                RF_Ra_addr = r_ir[3*RAW-1:2*RAW];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = r_ir[3*RAW-1:2*RAW];
                RF_Rb_addr = r_ir[2*RAW-1:RAW];
                RF_W_addr  = r_ir[RAW-1:0];
                ALU_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
                RF_W_en    = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: an instruction-level program model predicts the per-cycle
// control outputs; a monitor compares every cycle. A behavioural PC counter feeds Instr from imem.
module tb_cpu_controller;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
    } out_t;

    typedef struct {
        out_t o;
        int   idx;
    } exp_t;

    logic        clk;
    logic        Clr_n;
    logic [15:0] Instr;
    logic        PC_clr, PC_up, D_wr, RF_s, RF_W_en, Halted;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]  ALU_s0;

    logic [15:0] imem [128];
    logic [6:0]  pc;
    exp_t        sb_q [$];
    int          n_checks;
    int          n_errors;
    out_t        act;

    cpu_controller #(.IW(16), .DAW(8), .RAW(4)) dut (
        .Clock      (clk),
        .Clr_n      (Clr_n),
        .Instr      (Instr),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter owned by the datapath; wraps 127 -> 0 naturally.
    always @(posedge clk) begin
        if (PC_clr)     pc <= 7'd0;
        else if (PC_up) pc <= pc + 7'd1;
    end

    assign Instr = imem[pc];
    assign act = {PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                  RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (act !== e.o) begin
                n_errors++;
                $display("FAIL cycle_%0d outputs: got %h expected %h", e.idx, act, e.o);
            end
        end
    end

    // Expected per-cycle outputs derived instruction by instruction from the program.
    task automatic build_trace(input int ncyc);
        out_t tr [$];
        out_t o;
        logic [15:0] ins;
        int p;
        p = 0;
        while (tr.size() < ncyc) begin
            ins = imem[p];
            p = (p + 1) % 128;
            o = '0; o.pc_up = 1'b1; tr.push_back(o);
            o = '0; tr.push_back(o);
            case (ins[15:12])
                4'h1: begin
                    o = '0; o.d_addr = ins[7:0]; o.ra = ins[11:8]; o.d_wr = 1'b1;
                    tr.push_back(o);
                end
                4'h2: begin
                    o = '0; o.d_addr = ins[11:4]; o.rf_s = 1'b1; o.w_addr = ins[3:0];
                    tr.push_back(o);
                    o.w_en = 1'b1;
                    tr.push_back(o);
                end
                4'h3, 4'h4: begin
                    o = '0; o.ra = ins[11:8]; o.rb = ins[7:4]; o.w_addr = ins[3:0];
                    o.alu = (ins[15:12] == 4'h3) ? 3'b001 : 3'b010; o.w_en = 1'b1;
                    tr.push_back(o);
                end
                4'h5: begin
                    while (tr.size() < ncyc) begin
                        o = '0; o.halted = 1'b1; tr.push_back(o);
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < ncyc; i++) sb_q.push_back('{o: tr[i], idx: i});
    endtask

    // Entered at negedge+1: asserts reset there (possibly mid-instruction), releases after three
    // rising edges, then lets the monitor consume ncyc predicted cycles.
    task automatic run_prog(input int ncyc);
        out_t r;
        Clr_n = 1'b0;
        #1;
        r = '0; r.pc_clr = 1'b1;
        n_checks++;
        if (act !== r) begin
            n_errors++;
            $display("FAIL async_reset outputs: got %h expected %h", act, r);
        end
        sb_q.push_back('{o: r, idx: -3});
        sb_q.push_back('{o: r, idx: -2});
        sb_q.push_back('{o: r, idx: -1});
        build_trace(ncyc);
        repeat (3) @(posedge clk);
        #1 Clr_n = 1'b1;
        for (int t = 0; t < ncyc + 50 && sb_q.size() > 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pc = 7'd0;
        Clr_n = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        @(negedge clk);
        #1;

        // Directed program: LOAD, ADD, SUB, STORE, illegal opcode, HALT.
        imem[0] = 16'h2053;
        imem[1] = 16'h3124;
        imem[2] = 16'h4415;
        imem[3] = 16'h162A;
        imem[4] = 16'hF000;
        imem[5] = 16'h5000;
        run_prog(4 + 3 + 3 + 3 + 2 + 2 + 12);

        // Stop inside LOAD_A; the next run's reset lands mid-instruction.
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        imem[0] = 16'h2053;
        imem[1] = 16'h2077;
        run_prog(3);
        run_prog(8);

        // Random programs, halts allowed, random cut points.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 128; i++) imem[i] = 16'($urandom);
            for (int i = 0; i < 128; i++)
                if ($urandom_range(0, 2) == 0) imem[i][15:12] = 4'($urandom_range(0, 5));
            run_prog($urandom_range(5, 80));
        end

        // No halts: execution runs past PC 127 and wraps to 0.
        for (int i = 0; i < 128; i++) begin
            imem[i] = 16'($urandom);
            if (imem[i][15:12] == 4'h5) imem[i][15:12] = 4'h0;
        end
        run_prog(600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
